// File: rtl/stage_wb.sv
// MEM/WB register, write-back select, store-data forward select and matrix-line (MtypeL) assembly.
// One-cycle latency; stall holds WB, flush wins over stall; WB_RETIRE_CNT_EN enables the 64-bit retire counter.
module stage_wb #(
   parameter int LINE_WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     me_valid,
   input  logic [31:0]              me_inst,
   input  logic [31:0]              me_alu_o,
   input  logic [31:0]              me_mem_data,
   input  logic                     me_mem2reg,
   input  logic                     me_regs_write,
   input  logic                     me_mem_write,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     w_regs_en,
   output logic [4:0]               w_regs_addr,
   output logic [31:0]              w_regs_data,
   output logic                     forward_data,
   output logic [32*LINE_WORDS-1:0] wb_matrix_line,
   output logic                     wb_matrix_line_valid,
   output logic [63:0]              wb_retire_cnt
);

   // MtypeL: {funct3, opcode} on the custom-0 opcode space
   localparam logic [9:0] MTYPEL = {3'b110, 7'b0001011};
   localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] alu_o;
      logic [31:0] mem_data;
      logic        mem2reg;
      logic        regs_write;
   } memwb_t;

   memwb_t                         wb;
   logic [BW-1:0]                  beat;
   logic [LINE_WORDS-1:0][31:0]    line_buf;
   logic                           line_vld;
   logic [4:0]                     rd;
   logic                           is_mtl;
   logic                           wb_fire;
   logic                           unused_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         wb <= '0;
      end else if (flush) begin
         wb.valid <= 1'b0;
      end else if (!stall) begin
         wb <= '{valid: me_valid, inst: me_inst, alu_o: me_alu_o, mem_data: me_mem_data,
                 mem2reg: me_mem2reg, regs_write: me_regs_write};
      end
   end

   assign rd        = wb.inst[11:7];
   assign is_mtl    = ({wb.inst[14:12], wb.inst[6:0]} == MTYPEL);
   assign wb_fire   = wb.valid & ~stall;
   assign unused_ok = ^wb.inst[31:15];

   assign w_regs_en    = wb.valid & wb.regs_write & (rd != 5'd0) & ~is_mtl;
   assign w_regs_addr  = rd;
   assign w_regs_data  = wb.mem2reg ? wb.mem_data : wb.alu_o;
   assign forward_data = w_regs_en & me_mem_write & (me_inst[24:20] == rd);

   // Line buffer survives flush: words already in WB are committed
   always_ff @(posedge clk) begin
      if (rst) begin
         beat     <= '0;
         line_buf <= '0;
         line_vld <= 1'b0;
      end else begin
         line_vld <= 1'b0;
         if (wb_fire && is_mtl) begin
            line_buf[beat] <= wb.mem_data;
            if (beat == BW'(LINE_WORDS - 1)) begin
               beat     <= '0;
               line_vld <= 1'b1;
            end else begin
               beat <= beat + BW'(1);
            end
         end
      end
   end

   assign wb_matrix_line       = line_buf;
   assign wb_matrix_line_valid = line_vld;

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if (wb_fire) begin
         retire_cnt <= retire_cnt + 64'd1;
      end
   end

   assign wb_retire_cnt = retire_cnt;
`else
   assign wb_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_wb.sv
// Directed + randomized checks of stage_wb against a transaction-level reference model.
module tb_stage_wb;
   localparam int LW = 4;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_MTL = 7'b0001011;
   localparam logic [2:0] F3_MTL = 3'b110;

   logic clk = 1'b0;
   logic rst, me_valid, me_mem2reg, me_regs_write, me_mem_write, stall, flush;
   logic [31:0] me_inst, me_alu_o, me_mem_data;
   logic w_regs_en, forward_data, wb_matrix_line_valid;
   logic [4:0] w_regs_addr;
   logic [31:0] w_regs_data;
   logic [32*LW-1:0] wb_matrix_line;
   logic [63:0] wb_retire_cnt;

   int tests = 0;
   int fails = 0;

   // reference model: the instruction sitting in WB, words of the line in progress
   logic        m_v, m_m2r, m_rw, m_pulse;
   logic [31:0] m_inst, m_alu, m_mem;
   logic [31:0] m_q[$];
   logic [31:0] m_line[LW];
   longint unsigned m_retire;

   always #5 clk = ~clk;

   stage_wb #(.LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst), .me_valid(me_valid), .me_inst(me_inst), .me_alu_o(me_alu_o),
      .me_mem_data(me_mem_data), .me_mem2reg(me_mem2reg), .me_regs_write(me_regs_write),
      .me_mem_write(me_mem_write), .stall(stall), .flush(flush), .w_regs_en(w_regs_en),
      .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data), .forward_data(forward_data),
      .wb_matrix_line(wb_matrix_line), .wb_matrix_line_valid(wb_matrix_line_valid),
      .wb_retire_cnt(wb_retire_cnt)
   );

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs2);
      return {7'd0, rs2, 5'd1, f3, rd, op};
   endfunction

   function automatic logic is_mtl(input logic [31:0] i);
      return (i[6:0] == OP_MTL) && (i[14:12] == F3_MTL);
   endfunction

   function automatic logic exp_en();
      return m_v && m_rw && (m_inst[11:7] != 5'd0) && !is_mtl(m_inst);
   endfunction

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_fwd();
      chk("forward_data", 256'(forward_data),
          256'(exp_en() && me_mem_write && (me_inst[24:20] == m_inst[11:7])));
   endtask

   task automatic check_all();
      logic [32*LW-1:0] line;
      for (int i = 0; i < LW; i++) line[i*32 +: 32] = m_line[i];
      chk("w_regs_en", 256'(w_regs_en), 256'(exp_en()));
      chk("w_regs_addr", 256'(w_regs_addr), 256'(m_inst[11:7]));
      chk("w_regs_data", 256'(w_regs_data), 256'(m_m2r ? m_mem : m_alu));
      chk("line_valid", 256'(wb_matrix_line_valid), 256'(m_pulse));
      chk("matrix_line", 256'(wb_matrix_line), 256'(line));
`ifdef WB_RETIRE_CNT_EN
      chk("retire_cnt", 256'(wb_retire_cnt), 256'(m_retire));
`else
      chk("retire_cnt", 256'(wb_retire_cnt), 256'(0));
`endif
      chk_fwd();
   endtask

   task automatic cycle();
      @(posedge clk);
      m_pulse = 1'b0;
      if (rst) begin
         {m_v, m_m2r, m_rw} = '0;
         {m_inst, m_alu, m_mem} = '0;
         m_q.delete();
         for (int i = 0; i < LW; i++) m_line[i] = '0;
         m_retire = 0;
      end else begin
         if (m_v && !stall) begin
            m_retire++;
            if (is_mtl(m_inst)) begin
               m_line[m_q.size()] = m_mem;
               m_q.push_back(m_mem);
               if (m_q.size() == LW) begin
                  m_pulse = 1'b1;
                  m_q.delete();
               end
            end
         end
         if (flush) m_v = 1'b0;
         else if (!stall) begin
            m_v = me_valid; m_inst = me_inst; m_alu = me_alu_o;
            m_mem = me_mem_data; m_m2r = me_mem2reg; m_rw = me_regs_write;
         end
      end
      #1;
      check_all();
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] mem,
                        input logic m2r, input logic rw, input logic mw);
      me_valid = 1'b1; me_inst = inst; me_alu_o = alu; me_mem_data = mem;
      me_mem2reg = m2r; me_regs_write = rw; me_mem_write = mw;
   endtask

   initial begin
      int kind;
      logic [4:0] rd, rs2;
      logic [31:0] a, d;
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      me_valid = 1'b0;
      m_v = 1'b0; m_inst = '0; m_alu = '0; m_mem = '0; m_m2r = 1'b0; m_rw = 1'b0;
      m_pulse = 1'b0; m_retire = 0;
      for (int i = 0; i < LW; i++) m_line[i] = '0;
      cycle();
      cycle();
      rst = 1'b0;

      // ALU write-back
      drive(mk(OP_ADDI, 3'b000, 5'd5, 5'd0), 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      chk("alu_wb_en", 256'(w_regs_en), 256'(1));
      chk("alu_wb_data", 256'(w_regs_data), 256'(32'h1234));

      // load then dependent store
      drive(mk(OP_LOAD, 3'b010, 5'd7, 5'd0), 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
      cycle();
      drive(mk(OP_STORE, 3'b010, 5'd0, 5'd7), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("fwd_match", 256'(forward_data), 256'(1));
      chk("fwd_data", 256'(w_regs_data), 256'(32'hDEADBEEF));
      me_inst = mk(OP_STORE, 3'b010, 5'd0, 5'd8);
      #1;
      chk("fwd_nomatch", 256'(forward_data), 256'(0));

      // x0 suppression
      drive(mk(OP_LOAD, 3'b010, 5'd0, 5'd0), 32'h0, 32'h55, 1'b1, 1'b1, 1'b0);
      cycle();
      drive(mk(OP_STORE, 3'b010, 5'd0, 5'd0), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("x0_en", 256'(w_regs_en), 256'(0));
      chk("x0_fwd", 256'(forward_data), 256'(0));

      // stall + flush: flush wins
      drive(mk(OP_ADDI, 3'b000, 5'd9, 5'd0), 32'h99, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      stall = 1'b1; flush = 1'b1;
      cycle();
      chk("flush_over_stall", 256'(w_regs_en), 256'(0));
      stall = 1'b0; flush = 1'b0;
      drive(mk(OP_ADDI, 3'b000, 5'd10, 5'd0), 32'hA0A0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      stall = 1'b1;
      drive(mk(OP_ADDI, 3'b000, 5'd11, 5'd0), 32'hBBBB, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_hold", 256'(w_regs_data), 256'(32'hA0A0));
      end
      stall = 1'b0;
      cycle();

      // matrix line with a stall before the third word
      for (int i = 0; i < LW; i++) begin
         drive(mk(OP_MTL, F3_MTL, 5'd3, 5'd0), 32'h0, 32'(8'h11 * (i + 1)), 1'b1, 1'b1, 1'b0);
         if (i == 2) begin
            stall = 1'b1;
            cycle();
            stall = 1'b0;
         end
         cycle();
         chk("mtl_no_wen", 256'(w_regs_en), 256'(0));
      end
      drive(mk(OP_ADDI, 3'b000, 5'd1, 5'd0), 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      cycle();
      chk("line_value", 256'(wb_matrix_line), 256'(128'h00000044_00000033_00000022_00000011));

      // reset mid-line
      for (int i = 0; i < 2; i++) begin
         drive(mk(OP_MTL, F3_MTL, 5'd0, 5'd0), 32'h0, 32'hE0 + 32'(i), 1'b1, 1'b1, 1'b0);
         cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int i = 0; i < LW; i++) begin
         drive(mk(OP_MTL, F3_MTL, 5'd0, 5'd0), 32'h0, 32'hA0 + 32'(i), 1'b1, 1'b1, 1'b0);
         cycle();
      end
      me_valid = 1'b0;
      cycle();
      cycle();
      chk("post_rst_line", 256'(wb_matrix_line), 256'(128'h000000A3_000000A2_000000A1_000000A0));
`ifdef WB_RETIRE_CNT_EN
      chk("post_rst_retire", 256'(wb_retire_cnt), 256'(4));
`else
      chk("post_rst_retire", 256'(wb_retire_cnt), 256'(0));
`endif

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         kind = int'($urandom_range(0, 5));
         rd   = 5'($urandom);
         rs2  = ($urandom_range(0, 1) == 1) ? m_inst[11:7] : 5'($urandom);
         a    = $urandom;
         d    = $urandom;
         case (kind)
            0: drive(mk(OP_ADDI, 3'b000, rd, rs2), a, d, 1'b0, 1'b1, 1'b0);
            1: drive(mk(OP_LOAD, 3'b010, rd, rs2), a, d, 1'b1, 1'b1, 1'b0);
            2: drive(mk(OP_STORE, 3'b010, rd, rs2), a, d, 1'b0, 1'b0, 1'b1);
            3, 4: drive(mk(OP_MTL, F3_MTL, rd, rs2), a, d, 1'b1, 1'($urandom), 1'b0);
            default: drive($urandom, a, d, 1'($urandom), 1'($urandom), 1'($urandom));
         endcase
         me_valid = ($urandom_range(0, 9) != 0);
         stall    = ($urandom_range(0, 4) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         rst      = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/stage_wb.md
# stage_wb

Write-back stage of the AdamRiscv pipeline: holds the MEM/WB pipeline register, selects the register-file write data, and drives the store-data forwarding select back into the memory stage. It also assembles matrix-line loads (`MtypeL`) word by word into a full line for the matrix unit. Sits directly downstream of `stage_mem` and feeds the register file and the matrix unit.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per matrix line; power of two, 2..8.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- me_valid  in  1  MEM stage holds a real instruction.
- me_inst  in  32  MEM-stage instruction word.
- me_alu_o  in  32  MEM-stage ALU result.
- me_mem_data  in  32  load data from `stage_mem`, already extended.
- me_mem2reg  in  1  write-back source is load data, not ALU.
- me_regs_write  in  1  instruction writes rd.
- me_mem_write  in  1  MEM-stage instruction is a store.
- stall  in  1  freeze MEM/WB register.
- flush  in  1  load a bubble into MEM/WB.
- w_regs_en  out  1  register-file write enable.
- w_regs_addr  out  5  register-file write address.
- w_regs_data  out  32  register-file write data; also the forwarding value into `stage_mem`.
- forward_data  out  1  select `w_regs_data` as store data in `stage_mem`.
- wb_matrix_line  out  32*LINE_WORDS  assembled line; word 0 in bits [31:0].
- wb_matrix_line_valid  out  1  one-cycle pulse: line complete.
- wb_retire_cnt  out  64  retired-instruction count.

## Operation
- MEM/WB register fields: valid, inst, alu_o, mem_data, mem2reg, regs_write.
- Update priority: rst > flush > stall > capture.
  - flush: valid<=0, other fields don't-care.
  - stall: hold all fields.
  - capture: load all fields from the me_* inputs.
- Decode: rd=inst[11:7]. is_mtl is true when {inst[14:12],inst[6:0]} equals the shared `MtypeL` encoding from define.vh.
- wb_fire = wb_valid & ~stall. The WB instruction is consumed exactly once, on its fire cycle.
- w_regs_en = wb_valid & wb_regs_write & (rd!=0) & ~is_mtl. This is combinational from the register. It may stay high for repeated cycles during a stall, which is idempotent.
- w_regs_addr = rd.
- w_regs_data = wb_mem2reg ? wb_mem_data : wb_alu_o.
- forward_data = w_regs_en & me_mem_write & (me_inst[24:20]==rd). It is combinational and uses the current WB contents.
- Matrix assembly:
  - On wb_fire & is_mtl: line_buf[beat] <= wb_mem_data, and beat increments modulo LINE_WORDS.
  - When the beat written is LINE_WORDS-1: assert wb_matrix_line_valid in the following cycle for exactly one cycle, and beat wraps to 0.
  - wb_matrix_line is stable from that pulse until the next `MtypeL` write.
- flush does not clear beat or line_buf. Words already in WB are committed.
- Retire count: increments by 1 on every wb_fire. It wraps at 2^64.

## Timing
- Reset values:
  - All outputs 0; wb_valid=0, beat=0, line_buf=0, retire count 0.
  - The register fields inst/alu_o/mem_data are also 0, so w_regs_data=0.
- Latency: a MEM-stage instruction captured at edge N drives w_regs_* during cycle N..N+1. The register file writes at edge N+1 when not stalled.
- Line pulse: the fire of the last word at edge N gives wb_matrix_line_valid high in cycle N+1..N+2.
- stall and flush asserted together: flush wins.
- A stall over a WB `MtypeL` does not advance beat or fire the pulse until stall drops.
- rst mid-line: the partial line is discarded, beat=0, and no pulse occurs.
- Back-to-back `MtypeL` across a line boundary: the pulse for line k coincides with word 0 of line k+1 being written. Both are legal.

## Configuration
- WB_RETIRE_CNT_EN defined: the 64-bit retire counter is implemented as above.
- WB_RETIRE_CNT_EN undefined: no counter flops; wb_retire_cnt is tied to 0. All other behaviour is identical.

## Test plan
- ALU write-back:
  - Stimulus: addi x5 (rd=5), me_alu_o=0x1234, mem2reg=0, regs_write=1, capture.
  - Response: next cycle w_regs_en=1, addr=5, data=0x1234.
- Load then dependent store:
  - Stimulus: lw x7 in WB with me_mem_data=0xDEADBEEF; sw with rs2=7 in MEM (me_mem_write=1).
  - Response: forward_data=1, w_regs_data=0xDEADBEEF. With rs2=8, forward_data=0.
- x0 suppression:
  - Stimulus: load to rd=0.
  - Response: w_regs_en=0 and forward_data=0 even when the store rs2=0.
- Flush/stall priority:
  - Stimulus: stall=1 and flush=1 together.
  - Response: wb_valid=0 next cycle. With stall alone, the fields hold for 3 cycles and the retire count rises by 1 only after stall drops.
- Matrix line:
  - Stimulus: four `MtypeL` fires with data 0x11,0x22,0x33,0x44 (LINE_WORDS=4), one stall cycle inserted before the third.
  - Response: a single one-cycle pulse with wb_matrix_line={0x44,0x33,0x22,0x11}, w_regs_en=0 throughout, beat back to 0.
- Reset mid-line:
  - Stimulus: two `MtypeL` fires, rst for 1 cycle, then four more.
  - Response: exactly one pulse, containing only the post-reset words. wb_retire_cnt=4 with WB_RETIRE_CNT_EN defined, 0 without.
